// File: rtl/bus_reg_pkg.sv
// bus_reg_pkg: shared FSM state type and index-width helper for the bus register bank.
package bus_reg_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ, ACK} state_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/bus_sync_edge.sv
// bus_sync_edge: STAGES-deep synchroniser with a falling-edge pulse.
// Edges are only reported once the chain holds real input samples, so a strobe held low across reset release is not a start.
module bus_sync_edge #(
  parameter int   STAGES  = 3,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic fall
);
  logic [STAGES-1:0] sync_q, sync_d, vld_q, vld_d;
  logic prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    vld_d  = {vld_q[STAGES-2:0], 1'b1};
    prev_d = vld_q[STAGES-1] & sync_q[STAGES-1];
    lvl    = sync_q[STAGES-1];
    fall   = prev_q & ~lvl;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      vld_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      vld_q  <= vld_d;
      prev_q <= prev_d;
    end
endmodule

// File: rtl/bus_reg_bank.sv
// bus_reg_bank: asynchronous-strobe bus register bank with byte enables and a fabric write port.
// Define BUS_REG_BANK_ADDR_ERR_EN to enable the sticky out-of-range err flag.
module bus_reg_bank
  import bus_reg_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 24,
  parameter int NUM_REGS    = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            address,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [DATA_W/8-1:0]          be,
  input  logic                         ws_n,
  input  logic                         rs_n,
  input  logic                         as,
  output logic [DATA_W-1:0]            data_out,
  output logic                         ack,
  output logic                         err,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  input  logic                         hw_we,
  input  logic [clog2(NUM_REGS)-1:0]   hw_idx,
  input  logic [DATA_W-1:0]            hw_d
);
  localparam int IW = clog2(NUM_REGS);
  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0] NR = (ADDR_W+1)'(NUM_REGS);
  state_t state_q, state_d;
  logic [NUM_REGS*DATA_W-1:0] regs_d;
  logic [DATA_W-1:0] data_out_q, data_out_d, rd_word;
  logic [SYNC_STAGES-1:0] as_q, as_d;
  logic ws_lvl, ws_fall, rs_lvl, rs_fall, as_s, start_w, start_r, in_range;
  logic [IW-1:0] idx;
  bus_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ws (
    .clk(clk), .rst(rst), .d(ws_n), .lvl(ws_lvl), .fall(ws_fall)
  );
  bus_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_rs (
    .clk(clk), .rst(rst), .d(rs_n), .lvl(rs_lvl), .fall(rs_fall)
  );
  always_comb begin
    as_d     = {as_q[SYNC_STAGES-2:0], as};
    as_s     = as_q[SYNC_STAGES-1];
    start_w  = ws_fall & as_s;
    start_r  = rs_fall & as_s;
    in_range = {1'b0, address} < NR;
    idx      = address[IW-1:0];
    ack      = state_q == ACK;
    state_d  = state_q == IDLE  ? (start_w ? WRITE : start_r ? READ : IDLE) :
               state_q == ACK   ? ((ws_lvl & rs_lvl) ? IDLE : ACK) : ACK;
    rd_word  = '0;
    regs_d   = regs_q;
    // Bus commit is applied after the fabric write so it wins a same-register collision.
    for (int k = 0; k < NUM_REGS; k++) begin
      if (in_range && idx == IW'(k)) rd_word = regs_q[k*DATA_W +: DATA_W];
      if (hw_we && hw_idx == IW'(k)) regs_d[k*DATA_W +: DATA_W] = hw_d;
      if (state_q == WRITE && in_range && idx == IW'(k))
        for (int b = 0; b < NB; b++)
          if (be[b]) regs_d[k*DATA_W + b*8 +: 8] = data_in[b*8 +: 8];
    end
    data_out_d = state_q == READ ? rd_word : data_out_q;
    data_out   = data_out_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      regs_q     <= '0;
      data_out_q <= '0;
      as_q       <= '0;
    end else begin
      state_q    <= state_d;
      regs_q     <= regs_d;
      data_out_q <= data_out_d;
      as_q       <= as_d;
    end
`ifdef BUS_REG_BANK_ADDR_ERR_EN
  logic err_q, err_d;
  always_comb begin
    err_d = err_q | (state_q == IDLE && (start_w | start_r) && !in_range);
    err   = err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) err_q <= 1'b0;
    else err_q <= err_d;
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bus_reg_bank.sv
// tb_bus_reg_bank: scoreboard bench for bus_reg_bank at default parameters.
module tb_bus_reg_bank;
  localparam int S = 3;
`ifdef BUS_REG_BANK_ADDR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [23:0] address = '0;
  logic [31:0] data_in = '0, data_out, hw_d = '0;
  logic [3:0] be = '0;
  logic ws_n = 1, rs_n = 1, as = 0, ack, err, hw_we = 0;
  logic [2:0] hw_idx = '0;
  logic [255:0] regs_q;
  int n_chk = 0, n_fail = 0;
  logic [31:0] mdl [8];
  typedef struct { bit is_rd; int idx; logic [31:0] val; string name; } exp_t;
  exp_t sb[$];

  bus_reg_bank dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in), .be(be),
    .ws_n(ws_n), .rs_n(rs_n), .as(as), .data_out(data_out), .ack(ack), .err(err),
    .regs_q(regs_q), .hw_we(hw_we), .hw_idx(hw_idx), .hw_d(hw_d)
  );
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [255:0] mdl_flat();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = mdl[k];
    return r;
  endfunction

  task automatic access(input bit w, input bit r, input logic [23:0] a, input logic [31:0] d,
                        input logic [3:0] b, output int lat, output int rel);
    @(negedge clk);
    address = a; data_in = d; be = b; as = 1; ws_n = !w; rs_n = !r;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ack) begin lat = i; break; end
    end
    ws_n = 1; rs_n = 1;
    rel = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (!ack) begin rel = i; break; end
    end
    as = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_chk++; if (regs_q !== '0) begin n_fail++; $display("FAIL reset_regs got %h exp 0", regs_q); end
    n_chk++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out got %h exp 0", data_out); end
    n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", ack); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    rst = 0;
    for (int k = 0; k < 8; k++) mdl[k] = '0;
    repeat (S + 2) @(negedge clk);
  endtask

  task automatic test_full_write();
    int lat, rel;
    exp_t e;
    mdl[3] = merge(mdl[3], 32'hDEADBEEF, 4'hF);
    sb.push_back('{0, 3, mdl[3], "full_write"});
    access(1, 0, 24'd3, 32'hDEADBEEF, 4'hF, lat, rel);
    n_chk++; if (lat !== S + 2) begin n_fail++; $display("FAIL full_write_ack_latency got %0d exp %0d", lat, S + 2); end
    n_chk++; if (rel === -1) begin n_fail++; $display("FAIL full_write_ack_release got timeout exp low"); end
    e = sb.pop_front();
    n_chk++; if (regs_q[e.idx*32 +: 32] !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, regs_q[e.idx*32 +: 32], e.val); end
  endtask

  task automatic test_byte_enable();
    int lat, rel;
    exp_t e;
    mdl[3] = merge(mdl[3], 32'h11223344, 4'b0101);
    sb.push_back('{0, 3, mdl[3], "byte_enable"});
    access(1, 0, 24'd3, 32'h11223344, 4'b0101, lat, rel);
    e = sb.pop_front();
    n_chk++; if (regs_q[e.idx*32 +: 32] !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, regs_q[e.idx*32 +: 32], e.val); end
    n_chk++; if (e.val !== 32'hDE22BE44) begin n_fail++; $display("FAIL byte_enable_model got %h exp DE22BE44", e.val); end
  endtask

  task automatic test_read();
    int lat, rel;
    exp_t e;
    sb.push_back('{1, 3, mdl[3], "read_reg3"});
    access(0, 1, 24'd3, 32'h0, 4'h0, lat, rel);
    n_chk++; if (lat !== S + 2) begin n_fail++; $display("FAIL read_ack_latency got %0d exp %0d", lat, S + 2); end
    e = sb.pop_front();
    n_chk++; if (data_out !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, data_out, e.val); end
  endtask

  task automatic test_collision();
    int lat, rel, extra;
    exp_t e;
    logic [31:0] dout_before;
    dout_before = mdl[3];
    mdl[5] = 32'hA5A5A5A5;
    sb.push_back('{0, 5, mdl[5], "collision_reg5"});
    sb.push_back('{1, 0, dout_before, "collision_data_out"});
    access(1, 1, 24'd5, 32'hA5A5A5A5, 4'hF, lat, rel);
    extra = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (ack) extra++; end
    e = sb.pop_front();
    n_chk++; if (regs_q[e.idx*32 +: 32] !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, regs_q[e.idx*32 +: 32], e.val); end
    e = sb.pop_front();
    n_chk++; if (data_out !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, data_out, e.val); end
    n_chk++; if (lat !== S + 2 || extra !== 0) begin n_fail++; $display("FAIL collision_one_ack got lat %0d extra %0d exp lat %0d extra 0", lat, extra, S + 2); end
  endtask

  task automatic test_out_of_range();
    int lat, rel;
    exp_t e;
    sb.push_back('{1, 8, 32'h0, "oor_read_data_out"});
    access(0, 1, 24'd8, 32'h0, 4'h0, lat, rel);
    e = sb.pop_front();
    n_chk++; if (data_out !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, data_out, e.val); end
    n_chk++; if (lat !== S + 2) begin n_fail++; $display("FAIL oor_ack_latency got %0d exp %0d", lat, S + 2); end
    n_chk++; if (err !== ERR_EN) begin n_fail++; $display("FAIL oor_err got %b exp %b", err, ERR_EN); end
    access(1, 0, 24'h100003, 32'hFFFFFFFF, 4'hF, lat, rel);
    access(1, 0, 24'd8, 32'hFFFFFFFF, 4'hF, lat, rel);
    n_chk++; if (regs_q !== mdl_flat()) begin n_fail++; $display("FAIL oor_write_no_change got %h exp %h", regs_q, mdl_flat()); end
    mdl[7] = 32'h7777_0007;
    sb.push_back('{0, 7, mdl[7], "last_reg_write"});
    access(1, 0, 24'd7, 32'h7777_0007, 4'hF, lat, rel);
    e = sb.pop_front();
    n_chk++; if (regs_q[e.idx*32 +: 32] !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, regs_q[e.idx*32 +: 32], e.val); end
  endtask

  task automatic test_hw_write();
    @(negedge clk);
    hw_we = 1; hw_idx = 3'd6; hw_d = 32'hC0DE0006;
    mdl[6] = 32'hC0DE0006;
    @(negedge clk);
    hw_we = 0;
    n_chk++; if (regs_q[6*32 +: 32] !== mdl[6]) begin n_fail++; $display("FAIL hw_write got %h exp %h", regs_q[6*32 +: 32], mdl[6]); end
  endtask

  task automatic test_hw_collision();
    exp_t e;
    int waited;
    mdl[2] = 32'h2;
    sb.push_back('{0, 2, mdl[2], "hw_collision_reg2"});
    @(negedge clk);
    address = 24'd2; data_in = 32'h2; be = 4'hF; as = 1; ws_n = 0;
    repeat (S + 1) @(negedge clk);
    hw_we = 1; hw_idx = 3'd2; hw_d = 32'h1;
    @(negedge clk);
    hw_we = 0;
    n_chk++; if (ack !== 1'b1) begin n_fail++; $display("FAIL hw_collision_ack got %b exp 1", ack); end
    e = sb.pop_front();
    n_chk++; if (regs_q[e.idx*32 +: 32] !== e.val) begin n_fail++; $display("FAIL %s got %h exp %h", e.name, regs_q[e.idx*32 +: 32], e.val); end
    ws_n = 1;
    waited = 0;
    while (ack && waited < 20) begin @(negedge clk); waited++; end
    n_chk++; if (ack !== 1'b0) begin n_fail++; $display("FAIL hw_collision_release got %b exp 0", ack); end
    as = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_write();
    int acks;
    @(negedge clk);
    address = 24'd1; data_in = 32'hFFFFFFFF; be = 4'hF; as = 1; ws_n = 0;
    repeat (S + 1) @(negedge clk);
    rst = 1;
    #1;
    n_chk++; if (regs_q !== '0) begin n_fail++; $display("FAIL rst_in_write_regs got %h exp 0", regs_q); end
    n_chk++; if (ack !== 1'b0 || data_out !== '0 || err !== 1'b0) begin n_fail++; $display("FAIL rst_in_write_outs got ack %b dout %h err %b exp 0", ack, data_out, err); end
    @(negedge clk);
    rst = 0;
    acks = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (ack) acks++; end
    n_chk++; if (acks !== 0) begin n_fail++; $display("FAIL rst_no_ack_after_release got %0d acks exp 0", acks); end
    n_chk++; if (regs_q !== '0) begin n_fail++; $display("FAIL rst_no_write_after_release got %h exp 0", regs_q); end
    ws_n = 1; as = 0;
    repeat (S + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_byte_enable();
    test_read();
    test_collision();
    test_out_of_range();
    test_hw_write();
    test_hw_collision();
    test_reset_in_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
